// File: rtl/skip_adder_arbiter.sv
// rtl/skip_adder_arbiter.sv - round-robin per-transaction sharing of one external adder for multi-word adds
// Optional signed-overflow flag on the final word: define SKIP_ARB_OVF_EN.
module skip_adder_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req0_last,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    input  logic             req1_last,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_ci,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_co,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_co,
    output logic             rsp_last,
    output logic             rsp_id,
    output logic             rsp_ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOCK0 = 2'd1,
        S_LOCK1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             carry_q, carry_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_co_q, rsp_co_d;
    logic             rsp_last_q, rsp_last_d;
    logic             rsp_id_q, rsp_id_d;
    logic             free, sel, accept, sel_last;
`ifdef SKIP_ARB_OVF_EN
    logic             rsp_ovf_q, rsp_ovf_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            prio_q      <= 1'b0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_co_q    <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_id_q    <= 1'b0;
`ifdef SKIP_ARB_OVF_EN
            rsp_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            carry_q     <= carry_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_co_q    <= rsp_co_d;
            rsp_last_q  <= rsp_last_d;
            rsp_id_q    <= rsp_id_d;
`ifdef SKIP_ARB_OVF_EN
            rsp_ovf_q   <= rsp_ovf_d;
`endif
        end
    end

    // Selection and handshake; with nobody valid in IDLE the adder follows prio_q.
    always_comb begin
        free       = !rsp_valid_q || rsp_ready;
        sel        = prio_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        add_ci     = carry_q;
        unique case (state_q)
            S_LOCK0: begin
                sel        = 1'b0;
                req0_ready = free;
            end
            S_LOCK1: begin
                sel        = 1'b1;
                req1_ready = free;
            end
            default: begin
                if (req0_valid && req1_valid) sel = prio_q;
                else if (req0_valid)          sel = 1'b0;
                else if (req1_valid)          sel = 1'b1;
                req0_ready = free && !sel;
                req1_ready = free && sel;
                add_ci     = sel ? req1_cin : req0_cin;
            end
        endcase
        if (!rst_n) begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
        add_a    = sel ? req1_a : req0_a;
        add_b    = sel ? req1_b : req0_b;
        accept   = sel ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
        sel_last = sel ? req1_last : req0_last;
    end

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        carry_d     = carry_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_co_d    = rsp_co_q;
        rsp_last_d  = rsp_last_q;
        rsp_id_d    = rsp_id_q;
`ifdef SKIP_ARB_OVF_EN
        rsp_ovf_d   = rsp_ovf_q;
`endif
        if (accept) begin
            carry_d     = add_co;
            rsp_valid_d = 1'b1;
            rsp_sum_d   = add_s;
            rsp_co_d    = add_co;
            rsp_last_d  = sel_last;
            rsp_id_d    = sel;
`ifdef SKIP_ARB_OVF_EN
            // Carry into the MSB differs from carry out of it exactly on signed overflow.
            rsp_ovf_d   = sel_last && (add_co ^ (add_s[WIDTH-1] ^ add_a[WIDTH-1] ^ add_b[WIDTH-1]));
`endif
            if (sel_last) begin
                state_d = S_IDLE;
                prio_d  = !sel;
            end else begin
                state_d = sel ? S_LOCK1 : S_LOCK0;
            end
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_co    = rsp_co_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_id    = rsp_id_q;
`ifdef SKIP_ARB_OVF_EN
    assign rsp_ovf   = rsp_ovf_q;
`else
    assign rsp_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_skip_adder_arbiter.sv
// tb/tb_skip_adder_arbiter.sv - directed and random checks of skip_adder_arbiter against a multi-precision model
module tb_skip_adder_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_cin, req0_last;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_cin, req1_last;
    logic [W-1:0] req1_a, req1_b;
    logic [W-1:0] add_a, add_b, add_s;
    logic         add_ci, add_co;
    logic         rsp_valid, rsp_ready, rsp_co, rsp_last, rsp_id, rsp_ovf;
    logic [W-1:0] rsp_sum;

    always #5 clk = ~clk;

    // Stand-in for the external adder.
    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_ci};

    skip_adder_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cin(req0_cin), .req0_last(req0_last),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cin(req1_cin), .req1_last(req1_last),
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_s(add_s), .add_co(add_co),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_co(rsp_co),
        .rsp_last(rsp_last), .rsp_id(rsp_id), .rsp_ovf(rsp_ovf)
    );

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         last;
    } word_t;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         last;
        logic         ovf;
    } rsp_t;

    word_t drv[2][$];
    word_t acc[2][$];
    rsp_t  exp_q[2][$];
    int    log_q[$];
    int    exp_log[$];
    int    checks = 0;
    int    errors = 0;
    bit    gaps = 0;
    bit    rand_rdy = 0;
    int    stall_at = -100;
    bit    prev_last = 1;
    int    prev_id = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Expected words come from whole-number addition of the concatenated operands.
    task automatic close_txn(input int id);
        logic [127:0] big_a, big_b, part, mask;
        logic         c;
        longint       sv;
        rsp_t         r;
        int           n;
        n     = acc[id].size();
        big_a = '0;
        big_b = '0;
        for (int i = 0; i < n; i++) begin
            big_a[32*i +: 32] = acc[id][i].a;
            big_b[32*i +: 32] = acc[id][i].b;
        end
        c = acc[id][0].cin;
        for (int i = 0; i < n; i++) begin
            mask   = (128'd1 << (32*(i+1))) - 128'd1;
            part   = (big_a & mask) + (big_b & mask) + {127'd0, acc[id][0].cin};
            r.sum  = part[32*i +: 32];
            r.co   = part[32*(i+1)];
            r.last = (i == n-1);
            sv = longint'($signed(acc[id][i].a)) + longint'($signed(acc[id][i].b)) + (c ? 64'sd1 : 64'sd0);
`ifdef SKIP_ARB_OVF_EN
            r.ovf = r.last && (sv > 64'sd2147483647 || sv < -64'sd2147483648);
`else
            r.ovf = 1'b0;
`endif
            c = r.co;
            exp_q[id].push_back(r);
        end
        acc[id].delete();
    endtask

    task automatic push_word(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input logic last);
        word_t w;
        w = '{a: a, b: b, cin: cin, last: last};
        drv[id].push_back(w);
        acc[id].push_back(w);
        if (last) close_txn(id);
    endtask

    task automatic rand_txn(input int id, input int n);
        for (int i = 0; i < n; i++)
            push_word(id, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom, $urandom,
                      1'($urandom_range(0, 1)), i == n-1);
    endtask

    task automatic drive(input int id, input bit v, input word_t w);
        if (id == 0) begin
            req0_valid = v; req0_a = w.a; req0_b = w.b; req0_cin = w.cin; req0_last = w.last;
        end else begin
            req1_valid = v; req1_a = w.a; req1_b = w.b; req1_cin = w.cin; req1_last = w.last;
        end
    endtask

    task automatic run(input int budget, input int stop_after);
        int    cyc = 0;
        int    nacc = 0;
        int    id;
        bit    done = 0;
        bit    stall, a0, a1;
        bit    v[2];
        word_t w;
        rsp_t  h;
        while (!done) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                v[i] = drv[i].size() != 0 && !(gaps && $urandom_range(0, 3) == 0);
                w    = drv[i].size() != 0 ? drv[i][0] : word_t'({$urandom, $urandom, 2'b00});
                drive(i, v[i], w);
            end
            stall     = cyc >= stall_at && cyc < stall_at + 5;
            rsp_ready = stall ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            #1;
            if (stall) begin
                chk("stall_rsp_valid", rsp_valid, 1);
                chk("stall_req0_ready", req0_ready, 0);
                chk("stall_req1_ready", req1_ready, 0);
            end
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            if (a0 && a1) chk("double_grant", {a0, a1}, 2'b01);
            if (rsp_valid) begin
                id = int'(rsp_id);
                if (exp_q[id].size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    h = exp_q[id][0];
                    chk("rsp_sum", rsp_sum, h.sum);
                    chk("rsp_co", rsp_co, h.co);
                    chk("rsp_last", rsp_last, h.last);
                    chk("rsp_ovf", rsp_ovf, h.ovf);
                    if (rsp_ready) void'(exp_q[id].pop_front());
                end
            end
            if (a0 || a1) begin
                id = a1 ? 1 : 0;
                if (!prev_last) chk("grant_hold", id, prev_id);
                prev_last = drv[id][0].last;
                prev_id   = id;
                log_q.push_back(id);
                void'(drv[id].pop_front());
                nacc++;
            end
            cyc++;
            if (stop_after > 0 && nacc >= stop_after) done = 1;
            else if (drv[0].size() == 0 && drv[1].size() == 0 &&
                     exp_q[0].size() == 0 && exp_q[1].size() == 0) done = 1;
            else if (cyc > budget) begin
                chk("timeout_cycles", cyc, budget);
                done = 1;
            end
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic chk_log(input int e[$]);
        chk("grant_count", log_q.size(), e.size());
        for (int i = 0; i < e.size(); i++)
            if (i < log_q.size()) chk("grant_order", log_q[i], e[i]);
        log_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b1, '0);
        drive(1, 1'b1, '0);
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_co", rsp_co, 0);
        chk("rst_rsp_last", rsp_last, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_ovf", rsp_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        push_word(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
        run(200, 0);
        exp_log = '{0};
        chk_log(exp_log);

        push_word(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        push_word(1, 32'h0, 32'h0, 1'b0, 1'b1);
        run(200, 0);
        exp_log = '{1, 1};
        chk_log(exp_log);

        rand_txn(0, 3);
        rand_txn(1, 2);
        run(200, 0);
        exp_log = '{0, 0, 0, 1, 1};
        chk_log(exp_log);

        rand_txn(0, 1);
        run(200, 0);
        exp_log = '{0};
        chk_log(exp_log);
        rand_txn(0, 2);
        rand_txn(1, 2);
        run(200, 0);
        exp_log = '{1, 1, 0, 0};
        chk_log(exp_log);

        push_word(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        push_word(0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        push_word(0, 32'h1, 32'h2, 1'b0, 1'b1);
        stall_at = 2;
        run(200, 0);
        stall_at = -100;
        exp_log = '{0, 0, 0};
        chk_log(exp_log);

        push_word(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
        push_word(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        push_word(1, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1);
        run(200, 0);
        log_q.delete();

        gaps     = 1;
        rand_rdy = 1;
        for (int t = 0; t < 40; t++) rand_txn(int'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
        run(4000, 0);
        gaps     = 0;
        rand_rdy = 0;
        log_q.delete();

        rand_txn(0, 3);
        run(200, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        for (int i = 0; i < 2; i++) begin
            drv[i].delete();
            acc[i].delete();
            exp_q[i].delete();
        end
        log_q.delete();
        prev_last = 1;
        rst_n = 1'b1;
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd6; req1_cin = 1'b1; req1_last = 1'b1;
        rsp_ready  = 1'b1;
        #1;
        chk("post_rst_req1_ready", req1_ready, 1);
        chk("post_rst_add_ci", add_ci, 1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        chk("post_rst_rsp_valid", rsp_valid, 1);
        chk("post_rst_rsp_sum", rsp_sum, 32'd12);
        chk("post_rst_rsp_id", rsp_id, 1);
        chk("post_rst_rsp_last", rsp_last, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/skip_adder_arbiter.md
# skip_adder_arbiter

Shares one external 32-bit carry-skip adder (`skip_adder32`) between two requesters that issue multi-word (multi-precision) additions. Each requester streams operand word pairs, least-significant word first. The block grants the adder round-robin per transaction and holds the grant until that transaction's last word. Between words it keeps the inter-word carry in a register and returns each sum word through a one-deep registered response buffer tagged with the requester id.

## Interface
- `WIDTH`, 32: adder/word width; must match the attached adder.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `req0_valid` in 1 / `req0_ready` out 1: requester 0 word handshake.
- `req0_a`, `req0_b` in WIDTH: requester 0 operand word.
- `req0_cin` in 1: carry-in, used only on the first word of a transaction.
- `req0_last` in 1: marks the final word of the transaction.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cin`, `req1_last`: same for requester 1.
- `add_a`, `add_b` out WIDTH, `add_ci` out 1: drive the shared adder inputs.
- `add_s` in WIDTH, `add_co` in 1: adder outputs (combinational path from `add_*` outputs).
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_sum` out WIDTH, `rsp_co` out 1: sum word and carry-out of that word.
- `rsp_last` out 1, `rsp_id` out 1: last-word flag and requester id (0/1).
- `rsp_ovf` out 1: signed overflow of the final word (see Configuration).

## Operation
- State machine: IDLE, LOCK0, LOCK1. `carry_q` holds the carry between words. `prio_q` is the round-robin pointer.
- Buffer free condition: `free = !rsp_valid || rsp_ready`.
- IDLE behaviour:
  - Winner is the valid requester. If both are valid, the winner is the one `prio_q` points to.
  - The winner's `reqN_ready = free`; the loser's ready is 0.
  - On acceptance, `add_ci = reqN_cin`.
  - If `last = 1`, stay in IDLE and toggle `prio_q` to the other requester. Otherwise go to LOCKN.
- LOCKN behaviour:
  - Only requester N is muxed onto the adder. `reqN_ready = free`; the other ready is 0.
  - `add_ci = carry_q`.
  - On acceptance with `last = 1`, go to IDLE and set `prio_q` to the other requester.
- Adder inputs:
  - `add_a`/`add_b` always carry the currently selected requester's words.
  - In IDLE with no valid requester, they carry requester `prio_q`'s words. Their values do not matter when no word is accepted.
- On every accepted word:
  - `carry_q <= add_co`.
  - The response register loads `add_s`, `add_co`, `last`, and id, and `rsp_valid <= 1`.
- When the buffer is drained (`rsp_valid && rsp_ready`) and no word is accepted in the same cycle, `rsp_valid <= 0`.
- Arithmetic: modulo 2^WIDTH per word. The multi-word result is the concatenation of the response words, with the final `rsp_co` as the carry-out of the full result.
- No word count limit; a transaction may be any length of at least one word.
- `reqN_ready` never depends on `reqN_valid` of the other requester except in IDLE arbitration.

## Timing
- Latency: a word accepted in cycle T is visible on `rsp_*` in cycle T+1.
- Throughput: one word per cycle when `rsp_ready` is held at 1.
- Back-pressure: with `rsp_valid = 1` and `rsp_ready = 0`, both readies are 0 and all state is held.
- Simultaneous drain and accept: allowed in the same cycle; the buffer reloads and `rsp_valid` stays 1.
- Grant holding: held across idle gaps inside a transaction. In LOCKN, `reqN_valid = 0` leaves the state unchanged, and the other requester waits indefinitely.
- Reset values (`rst_n = 0` sampled at a clock edge):
  - state = IDLE, `prio_q` = 0 (points at requester 0), `carry_q` = 0.
  - `rsp_valid` = 0, `rsp_sum` = 0, `rsp_co` = 0, `rsp_last` = 0, `rsp_id` = 0, `rsp_ovf` = 0.
  - Both readies are 0 while reset is asserted.
- Reset mid-transaction: the in-flight transaction is abandoned and the buffered response is discarded. The first word after reset is treated as the start of a new transaction.

## Configuration
- Macro: `SKIP_ARB_OVF_EN`.
- Defined:
  - On an accepted word with `last = 1`, `rsp_ovf` loads `add_co ^ (add_s[WIDTH-1] ^ add_a[WIDTH-1] ^ add_b[WIDTH-1])`.
  - On all other words it loads 0.
- Undefined: `rsp_ovf` is constant 0 and no overflow logic is built.

## Test plan
- Single-word transaction: req0 sends a=0xFFFFFFFF, b=0x00000001, cin=0, last=1 → next cycle rsp_sum=0x00000000, rsp_co=1, rsp_last=1, rsp_id=0; state stays IDLE.
- Carry across words: req1 sends 2 words, {a=0xFFFFFFFF, b=0x1, cin=0}, then {a=0x0, b=0x0, last=1} → rsp words 0x00000000 (co=1), then 0x00000001 (co=0).
- Contention: both requesters valid in the same cycle after reset → req0 is granted and its 3-word transaction completes; req1_ready stays 0 throughout, then req1 is granted next.
  - Repeat the contention → req1 is granted first.
- Back-pressure: hold `rsp_ready=0` for 5 cycles mid-transaction → readies are 0, `rsp_*` are stable, and `carry_q` is preserved. Release → sums are correct with no duplicated or dropped words.
- Overflow (`SKIP_ARB_OVF_EN` defined): last word a=0x7FFFFFFF, b=0x00000001 → `rsp_ovf=1`. With the macro undefined → `rsp_ovf=0`.
- Reset mid-transaction: assert `rst_n=0` after word 1 of a 3-word req0 transaction → `rsp_valid=0` and state IDLE. A new req1 single word is then accepted with `add_ci = req1_cin`.
